// File: rtl/dbuf_seq.sv
// dbuf_seq: load/read sequencer in front of the 32-bit data buffer.
// Optional checksum of loaded words: define DBUF_SEQ_CKSUM_EN.
module dbuf_seq #(
    parameter int DEPTH = 49152,
    parameter int AW    = 17,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_go,
    input  logic          rd_go,
    input  logic [AW-1:0] rd_len,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last,
    input  logic          m_ready,
    output logic [DW-1:0] din,
    output logic [AW-1:0] didx,
    output logic          RW,
    input  logic [DW-1:0] di,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   wr_count,
    output logic          ovf,
    output logic [DW-1:0] cksum
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ} state_t;

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_out_idx;
    logic          r_s_ready;
    logic          r_done;
    logic          r_ovf;
    logic [AW:0]   r_wr_count;
    logic          r_pend;
    logic [1:0]    r_cnt;
    logic [DW-1:0] r_q0;
    logic [DW-1:0] r_q1;

    logic          w_wr;
    logic          w_load_end;
    logic          w_pop;
    logic          w_push;
    logic [1:0]    w_occ;
    logic          w_issue;
    logic [AW-1:0] w_len_c;
    logic          w_start_rd;
    logic          w_head_last;

    assign w_wr       = (r_state == S_LOAD) & r_s_ready & s_valid;
    assign w_load_end = w_wr & (s_last | (r_ptr == AW'(DEPTH - 1)));
    assign w_pop      = (r_cnt != 2'd0) & m_ready;
    assign w_push     = r_pend;
    // Occupancy seen by the next edge: in flight + buffered, minus a pop now.
    assign w_occ      = {1'b0, r_pend} + r_cnt - {1'b0, w_pop};
    assign w_issue    = (r_state == S_READ) & (r_rd_ptr != r_len)
                      & (w_occ < 2'd2);
    assign w_len_c    = (rd_len > AW'(DEPTH)) ? AW'(DEPTH) : rd_len;
    // In IDLE didx rests at 0, so the rd_go cycle itself reads address 0.
    assign w_start_rd = (r_state == S_IDLE) & rd_go & ~load_go
                      & (w_len_c != '0);
    assign w_head_last = (r_state == S_READ)
                       & (r_out_idx == r_len - AW'(1));

    assign s_ready  = r_s_ready;
    assign RW       = w_wr;
    assign din      = w_wr ? s_data : '0;
    assign didx     = w_wr ? r_ptr : (w_issue ? r_rd_ptr : '0);
    assign m_data   = r_q0;
    assign m_valid  = (r_cnt != 2'd0);
    assign m_last   = m_valid & w_head_last;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign wr_count = r_wr_count;
    assign ovf      = r_ovf;

    // Phase control FSM with its registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_len      <= '0;
            r_rd_ptr   <= '0;
            r_out_idx  <= '0;
            r_s_ready  <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (load_go) begin
                        r_state   <= S_LOAD;
                        r_s_ready <= 1'b1;
                        r_ptr     <= '0;
                        r_ovf     <= 1'b0;
                    end else if (rd_go) begin
                        if (w_len_c == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state   <= S_READ;
                            r_len     <= w_len_c;
                            r_rd_ptr  <= AW'(1);
                            r_out_idx <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_wr) begin
                        r_ptr <= r_ptr + AW'(1);
                        if (w_load_end) begin
                            r_state    <= S_IDLE;
                            r_s_ready  <= 1'b0;
                            r_done     <= 1'b1;
                            r_wr_count <= {1'b0, r_ptr} + (AW+1)'(1);
                            r_ovf      <= ~s_last;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                    end
                    if (w_pop) begin
                        r_out_idx <= r_out_idx + AW'(1);
                        if (w_head_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Track the read issued last cycle; its data lands on di this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_issue | w_start_rd;
        end
    end

    // Two-entry skid FIFO; r_q0 is always the head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_q0  <= '0;
            r_q1  <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_q0 <= di;
                    else               r_q1 <= di;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_q0  <= r_q1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_q0 <= di;
                    end else begin
                        r_q0 <= r_q1;
                        r_q1 <= di;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DBUF_SEQ_CKSUM_EN
    logic [DW-1:0] r_cksum;
    assign cksum = r_cksum;

    // Running sum of accepted load words, restarted by each load_go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cksum <= '0;
        end else if (r_state == S_IDLE && load_go) begin
            r_cksum <= '0;
        end else if (w_wr) begin
            r_cksum <= r_cksum + s_data;
        end
    end
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_dbuf_seq.sv
// tb_dbuf_seq: directed bench for dbuf_seq with a behavioural buffer.
// Build with DBUF_SEQ_CKSUM_EN to expect the running checksum.
module tb_dbuf_seq;

    localparam int DEPTH = 49152;
    localparam int AW    = 17;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_go;
    logic          rd_go;
    logic [AW-1:0] rd_len;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic [DW-1:0] din;
    logic [AW-1:0] didx;
    logic          RW;
    logic [DW-1:0] di;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
    logic          ovf;
    logic [DW-1:0] cksum;

    int errs   = 0;
    int checks = 0;
    int n_done = 0;
    int n_wr   = 0;
    int n_mv   = 0;
    logic [DW-1:0] exp_ck;
    logic [DW-1:0] mem [0:DEPTH-1];

    dbuf_seq #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_go(load_go), .rd_go(rd_go), .rd_len(rd_len),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready),
        .din(din), .didx(didx), .RW(RW), .di(di),
        .busy(busy), .done(done), .wr_count(wr_count),
        .ovf(ovf), .cksum(cksum)
    );

    always #5 clk = ~clk;

    // Behavioural buffer: synchronous write, registered read.
    always @(posedge clk) begin
        if (RW) mem[didx] <= din;
        di <= mem[didx];
    end

    always @(posedge clk) begin
        if (done) n_done++;
        if (RW) n_wr++;
        if (m_valid) n_mv++;
    end

    function automatic logic [DW-1:0] ck_exp(input logic [DW-1:0] v);
`ifdef DBUF_SEQ_CKSUM_EN
        return v;
`else
        return '0;
`endif
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if ({s_ready, m_valid, m_last, RW, busy, done, ovf} !== 7'b0) begin
            errs++;
            $display("FAIL reset_flags: got %b want 0",
                     {s_ready, m_valid, m_last, RW, busy, done, ovf});
        end
        checks++;
        if ({didx, din, m_data, wr_count, cksum} !== '0) begin
            errs++;
            $display("FAIL reset_data: got %0h want 0",
                     {didx, din, m_data, wr_count, cksum});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); load_go = 1'b1;
        @(negedge clk); load_go = 1'b0;
        s_valid = 1'b1; s_data = 32'h5;
        @(negedge clk); s_data = 32'h6;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, s_ready, RW} !== 3'b000) begin
            errs++;
            $display("FAIL reset_midload: got %b want 000",
                     {busy, s_ready, RW});
        end
        checks++;
        if ({didx, din} !== '0) begin
            errs++;
            $display("FAIL reset_midload_bus: got %0h want 0", {didx, din});
        end
        s_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_load4();
        logic [DW-1:0] w [4];
        int d0;
        w = '{32'h11, 32'h22, 32'h33, 32'h44};
        d0 = n_done;
        @(negedge clk); load_go = 1'b1;
        @(negedge clk); load_go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = w[i]; s_last = (i == 3);
            #1;
            checks++;
            if ({RW, didx, din} !== {1'b1, AW'(i), w[i]}) begin
                errs++;
                $display("FAIL load4_wr%0d: got RW=%b didx=%0d din=%0h want 1 %0d %0h",
                         i, RW, didx, din, i, w[i]);
            end
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
        checks++;
        if ({s_ready, done, busy, ovf} !== 4'b0100) begin
            errs++;
            $display("FAIL load4_end: got rdy/done/busy/ovf=%b want 0100",
                     {s_ready, done, busy, ovf});
        end
        checks++;
        if (wr_count !== 18'd4) begin
            errs++;
            $display("FAIL load4_count: got %0d want 4", wr_count);
        end
        checks++;
        if (cksum !== ck_exp(32'hAA)) begin
            errs++;
            $display("FAIL load4_cksum: got %0h want %0h", cksum, ck_exp(32'hAA));
        end
        @(negedge clk);
        checks++;
        if (n_done - d0 !== 1) begin
            errs++;
            $display("FAIL load4_done: got %0d pulses want 1", n_done - d0);
        end
    endtask

    task automatic test_read4();
        logic [DW-1:0] w [4];
        w = '{32'h11, 32'h22, 32'h33, 32'h44};
        m_ready = 1'b1;
        rd_go = 1'b1; rd_len = AW'(4);
        @(negedge clk); rd_go = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errs++;
            $display("FAIL read4_early: got m_valid=%b want 0", m_valid);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({m_valid, m_last, m_data} !== {1'b1, (i == 3), w[i]}) begin
                errs++;
                $display("FAIL read4_w%0d: got v=%b l=%b d=%0h want 1 %0d %0h",
                         i, m_valid, m_last, m_data, (i == 3), w[i]);
            end
            @(negedge clk);
        end
        checks++;
        if ({done, m_valid, busy} !== 3'b100) begin
            errs++;
            $display("FAIL read4_done: got done/v/busy=%b want 100",
                     {done, m_valid, busy});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errs++;
            $display("FAIL read4_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_stall8();
        int idx;
        int cyc;
        logic was_stall;
        logic [DW-1:0] held;
        @(negedge clk); load_go = 1'b1;
        @(negedge clk); load_go = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 32'h100 + i; s_last = (i == 7);
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
        rd_go = 1'b1; rd_len = AW'(8); m_ready = 1'b0;
        @(negedge clk); rd_go = 1'b0;
        idx = 0; cyc = 0; was_stall = 1'b0; held = '0;
        while (idx < 8 && cyc < 200) begin
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (was_stall) begin
                checks++;
                if ({m_valid, m_data} !== {1'b1, held}) begin
                    errs++;
                    $display("FAIL stall_hold: got v=%b d=%0h want 1 %0h",
                             m_valid, m_data, held);
                end
            end
            if (m_valid) begin
                checks++;
                if ({m_last, m_data} !== {(idx == 7), 32'h100 + idx}) begin
                    errs++;
                    $display("FAIL stall_w%0d: got l=%b d=%0h want %0d %0h",
                             idx, m_last, m_data, (idx == 7), 32'h100 + idx);
                end
                if (m_ready) idx++;
            end
            was_stall = m_valid & ~m_ready;
            held = m_data;
            cyc++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        checks++;
        if (idx !== 8) begin
            errs++;
            $display("FAIL stall_timeout: got %0d words want 8", idx);
        end
        checks++;
        if ({done, busy, m_valid} !== 3'b100) begin
            errs++;
            $display("FAIL stall_done: got done/busy/v=%b want 100",
                     {done, busy, m_valid});
        end
        @(negedge clk);
    endtask

    task automatic test_zero_len_and_ignore();
        int d0;
        int mv0;
        d0 = n_done; mv0 = n_mv;
        rd_go = 1'b1; rd_len = '0;
        @(negedge clk); rd_go = 1'b0;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errs++;
            $display("FAIL zlen_done: got done/busy=%b want 10", {done, busy});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (n_done - d0 !== 1 || n_mv != mv0) begin
            errs++;
            $display("FAIL zlen_pulse: got %0d pulses %0d valids want 1 0",
                     n_done - d0, n_mv - mv0);
        end
        load_go = 1'b1;
        @(negedge clk); load_go = 1'b0;
        rd_go = 1'b1; rd_len = AW'(4);
        @(negedge clk); rd_go = 1'b0;
        checks++;
        if ({busy, s_ready} !== 2'b11) begin
            errs++;
            $display("FAIL ignore_rdgo: got busy/rdy=%b want 11", {busy, s_ready});
        end
        s_valid = 1'b1; s_data = 32'h7; s_last = 1'b0;
        @(negedge clk);
        s_data = 32'h8; s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        checks++;
        if ({wr_count, busy, done} !== {18'd2, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL ignore_load: got cnt=%0d busy=%b done=%b want 2 0 1",
                     wr_count, busy, done);
        end
        checks++;
        if (cksum !== ck_exp(32'hF)) begin
            errs++;
            $display("FAIL ignore_cksum: got %0h want %0h", cksum, ck_exp(32'hF));
        end
        @(negedge clk);
        checks++;
        if (n_mv != mv0) begin
            errs++;
            $display("FAIL ignore_mvalid: got %0d valids want 0", n_mv - mv0);
        end
    endtask

    task automatic test_ovf();
        int w0;
        w0 = n_wr;
        exp_ck = '0;
        load_go = 1'b1;
        @(negedge clk); load_go = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            s_valid = 1'b1; s_data = DW'(i); s_last = 1'b0;
            if (i < DEPTH) exp_ck = exp_ck + DW'(i);
            if (i == DEPTH - 1) begin
                #1;
                checks++;
                if ({RW, didx} !== {1'b1, AW'(DEPTH - 1)}) begin
                    errs++;
                    $display("FAIL ovf_lastaddr: got RW=%b didx=%0d want 1 %0d",
                             RW, didx, DEPTH - 1);
                end
            end
            if (i == DEPTH) begin
                #1;
                checks++;
                if ({RW, s_ready, done} !== 3'b001) begin
                    errs++;
                    $display("FAIL ovf_stop: got RW/rdy/done=%b want 001",
                             {RW, s_ready, done});
                end
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if (n_wr - w0 !== DEPTH) begin
            errs++;
            $display("FAIL ovf_writes: got %0d want %0d", n_wr - w0, DEPTH);
        end
        checks++;
        if ({ovf, wr_count} !== {1'b1, 18'(DEPTH)}) begin
            errs++;
            $display("FAIL ovf_flag: got ovf=%b cnt=%0d want 1 %0d",
                     ovf, wr_count, DEPTH);
        end
        checks++;
        if (cksum !== ck_exp(exp_ck)) begin
            errs++;
            $display("FAIL ovf_cksum: got %0h want %0h", cksum, ck_exp(exp_ck));
        end
        load_go = 1'b1;
        @(negedge clk); load_go = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errs++;
            $display("FAIL ovf_clear: got %b want 0", ovf);
        end
        s_valid = 1'b1; s_data = 32'h9; s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        checks++;
        if ({ovf, wr_count, s_ready} !== {1'b0, 18'd1, 1'b0}) begin
            errs++;
            $display("FAIL ovf_reload: got ovf=%b cnt=%0d rdy=%b want 0 1 0",
                     ovf, wr_count, s_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0; load_go = 1'b0; rd_go = 1'b0; rd_len = '0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        test_reset();
        test_load4();
        test_read4();
        test_stall8();
        test_zero_len_and_ignore();
        test_ovf();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
